// File: rtl/cdb_pkg.sv
// Shared types for the common-data-bus broadcaster: default widths, label type
// and the broadcast triple seen by the register file and reservation stations.
package cdb_pkg;

    localparam int LW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef logic [LW_DEF-1:0] label_t;

    // Label 0 marks "no producer" and must never appear on the bus.
    localparam label_t NO_LABEL = '0;

    typedef struct packed {
        logic              en;
        label_t            label;
        logic [DW_DEF-1:0] data;
    } bcast_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the highest priority goes to ptr_i, then
// ptr_i+1, and so on, wrapping at NSRC. Returns a one-hot grant and its index.
module rr_arbiter #(
    parameter  int NSRC = 4,
    localparam int PW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NSRC-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    logic [2*NSRC-1:0] dbl;
    logic [2*NSRC-1:0] dbl_rot;
    logic [NSRC-1:0]   rot;
    logic [PW:0]       sum;

    // Rotating the doubled vector puts the ptr_i source at bit 0.
    always_comb begin
        dbl     = {req_i, req_i};
        dbl_rot = dbl >> ptr_i;
        rot     = dbl_rot[NSRC-1:0];
    end

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        gnt_o   = '0;
        for (int j = 0; j < NSRC; j++) begin
            if (!valid_o && rot[j]) begin
                valid_o = 1'b1;
                sum     = {1'b0, ptr_i} + (PW+1)'(j);
                if (sum >= (PW+1)'(NSRC)) begin
                    sum = sum - (PW+1)'(NSRC);
                end
                idx_o = sum[PW-1:0];
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            gnt_o[i] = valid_o && (idx_o == PW'(i));
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common-data-bus arbiter and registered broadcaster for the Tomasulo core.
// Optional CDB_STATS_EN adds bc_count and conflict_count statistics outputs.
module cdb_broadcaster
    import cdb_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int LW   = LW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              flush,
    input  logic [NSRC-1:0]   req,
    input  logic [NSRC*LW-1:0] req_label,
    input  logic [NSRC*DW-1:0] req_data,
    output logic [NSRC-1:0]   gnt,
    output logic              BCEN,
    output logic [LW-1:0]     BClabel,
    output logic [DW-1:0]     BCdata,
`ifdef CDB_STATS_EN
    output logic [31:0]       bc_count,
    output logic [31:0]       conflict_count,
`endif
    output logic              err_zero_label
);

    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef struct packed {
        logic          en;
        logic [LW-1:0] label;
        logic [DW-1:0] data;
    } bc_t;

    bc_t           bc_q, bc_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;

    logic [NSRC-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            arb_valid;
    logic            grant_v;
    logic [LW-1:0]   sel_label;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(.NSRC(NSRC)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Handshake: source i holds req[i], label and data stable until it sees
    // gnt[i]=1; the result is consumed on the posedge where req[i] & gnt[i].
    // There is no downstream ready: every grant is accepted at that edge.
    assign grant_v = arb_valid && !flush && nRST;
    assign gnt     = arb_gnt & {NSRC{grant_v}};

    always_comb begin
        sel_label = '0;
        sel_data  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (arb_idx == PW'(i)) begin
                sel_label = req_label[i*LW +: LW];
                sel_data  = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        bc_d    = bc_q;
        bc_d.en = 1'b0;
        ptr_d   = ptr_q;
        err_d   = err_q;
        if (grant_v) begin
            ptr_d = (arb_idx == PW'(NSRC-1)) ? '0 : arb_idx + 1'b1;
            if (sel_label == LW'(NO_LABEL)) begin
                err_d = 1'b1;
            end else begin
                bc_d.en    = 1'b1;
                bc_d.label = sel_label;
                bc_d.data  = sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            bc_q  <= '0;
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            bc_q  <= bc_d;
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    assign BCEN           = bc_q.en;
    assign BClabel        = bc_q.label;
    assign BCdata         = bc_q.data;
    assign err_zero_label = err_q;

`ifdef CDB_STATS_EN
    logic [31:0] bc_cnt_q, bc_cnt_d;
    logic [31:0] conf_cnt_q, conf_cnt_d;

    always_comb begin
        bc_cnt_d   = bc_cnt_q + 32'(bc_q.en);
        conf_cnt_d = conf_cnt_q;
        if (($countones(req) > 1) && !flush) begin
            conf_cnt_d = conf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            bc_cnt_q   <= '0;
            conf_cnt_q <= '0;
        end else begin
            bc_cnt_q   <= bc_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign bc_count       = bc_cnt_q;
    assign conflict_count = conf_cnt_q;
`endif

endmodule
